// File: rtl/vec_pkg.sv
// Shared types and sizes for the vector memory stage: lane/flag vectors,
// the memory-sequencer state encoding and the captured control bundle.
package vec_pkg;

  localparam int I  = 32;
  localparam int N  = 8;
  localparam int R  = 6;
  localparam int LW = (R > 1) ? $clog2(R) : 1;

  typedef logic [N-1:0]  lane_t;
  typedef lane_t [R-1:0] lanes_t;
  typedef logic [R-1:0][1:0] flags_t;
  typedef logic [LW-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE      = 2'd1,
    LOAD       = 2'd2,
    LOAD_DRAIN = 2'd3
  } mem_state_t;

  // Control fields that travel unchanged from execute to writeback.
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       flagswrite;
    logic [3:0] wa3;
    flags_t     flags;
  } ctrl_t;

  // Byte address of lane k; wraps modulo 2^I.
  function automatic logic [I-1:0] lane_addr(input logic [I-1:0] base, input lane_idx_t k);
    return base + I'(k);
  endfunction

endpackage

// File: rtl/vec_lane_seq.sv
// Lane counter and transfer FSM for the vector memory stage. Exposes the
// current state, lane index and last-lane flag; data muxing lives in the top.
module vec_lane_seq
  import vec_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_store,
  input  logic       start_load,
  output mem_state_t state_o,
  output lane_idx_t  lane_o,
  output logic       last_o
);

  mem_state_t state_q, state_d;
  lane_idx_t  lane_q, lane_d;
  logic       last;

  assign last = (lane_q == lane_idx_t'(R - 1));

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE: begin
        lane_d = '0;
        if (start_store) begin
          state_d = STORE;
        end else if (start_load) begin
          state_d = LOAD;
        end
      end
      STORE: begin
        if (last) begin
          state_d = IDLE;
          lane_d  = '0;
        end else begin
          lane_d = lane_q + lane_idx_t'(1);
        end
      end
      LOAD: begin
        if (last) begin
          state_d = LOAD_DRAIN;
          lane_d  = '0;
        end else begin
          lane_d = lane_q + lane_idx_t'(1);
        end
      end
      LOAD_DRAIN: begin
        state_d = IDLE;
        lane_d  = '0;
      end
      default: begin
        state_d = IDLE;
        lane_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  assign state_o = state_q;
  assign lane_o  = lane_q;
  assign last_o  = last;

endmodule

// File: rtl/vec_mem_stage.sv
// Vector memory stage: captures one instruction, moves its lanes byte-serially
// over a single-port memory, then emits one registered writeback bundle.
module vec_mem_stage
  import vec_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         InValid,
  input  logic         RegWriteE,
  input  logic         MemtoRegE,
  input  logic         MemWriteE,
  input  logic         FlagsWriteE,
  input  logic [3:0]   WA3E,
  input  lanes_t       ALUOutputE,
  input  lanes_t       WriteDataE,
  input  flags_t       ALUFlagsE,
  input  logic [I-1:0] A,
  output logic         Stall,
  output logic [I-1:0] MemAddr,
  output lane_t        MemWData,
  output logic         MemWE,
  input  lane_t        MemRData,
  output logic         WBValid,
  output logic         RegWriteW,
  output logic         MemtoRegW,
  output logic         FlagsWriteW,
  output logic [3:0]   WA3W,
  output flags_t       ALUFlagsW,
  output lanes_t       ResultW
);

  // Handshake: the instruction transfers on a cycle with InValid=1 and
  // Stall=0; while Stall=1 the execute stage must hold its outputs steady.

  mem_state_t state;
  lane_idx_t  lane;
  lane_idx_t  prev_lane;
  logic       last;
  logic       accept;
  logic       is_store;
  logic       is_load;
  ctrl_t      in_ctrl;

  ctrl_t          ctrl_q, ctrl_d;
  lanes_t         alu_q, alu_d;
  lanes_t         wdata_q, wdata_d;
  logic [I-1:0]   addr_q, addr_d;
  lanes_t         load_q, load_d;
  logic           wb_valid_q, wb_valid_d;
  ctrl_t          wb_ctrl_q, wb_ctrl_d;
  lanes_t         wb_result_q, wb_result_d;

  assign Stall    = (state != IDLE);
  assign accept   = InValid && !Stall;
  assign is_store = MemWriteE;
  assign is_load  = !MemWriteE && MemtoRegE;

  assign in_ctrl.regwrite   = RegWriteE;
  assign in_ctrl.memtoreg   = MemtoRegE;
  assign in_ctrl.flagswrite = FlagsWriteE;
  assign in_ctrl.wa3        = WA3E;
  assign in_ctrl.flags      = ALUFlagsE;

  vec_lane_seq u_seq (
    .clk         (clk),
    .reset       (reset),
    .start_store (accept && is_store),
    .start_load  (accept && is_load),
    .state_o     (state),
    .lane_o      (lane),
    .last_o      (last)
  );

  // Read data returns one cycle late, so it belongs to the previous lane.
  assign prev_lane = lane - lane_idx_t'(1);

  always_comb begin
    ctrl_d      = ctrl_q;
    alu_d       = alu_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    load_d      = load_q;
    wb_valid_d  = 1'b0;
    wb_ctrl_d   = wb_ctrl_q;
    wb_result_d = wb_result_q;

    if (accept) begin
      ctrl_d  = in_ctrl;
      alu_d   = ALUOutputE;
      wdata_d = WriteDataE;
      addr_d  = A;
      if (!is_store && !is_load) begin
        wb_valid_d  = 1'b1;
        wb_ctrl_d   = in_ctrl;
        wb_result_d = ALUOutputE;
      end
    end

    case (state)
      STORE: begin
        if (last) begin
          wb_valid_d  = 1'b1;
          wb_ctrl_d   = ctrl_q;
          wb_result_d = alu_q;
        end
      end
      LOAD: begin
        if (lane != '0) begin
          load_d[prev_lane] = MemRData;
        end
      end
      LOAD_DRAIN: begin
        load_d[R-1] = MemRData;
        wb_valid_d  = 1'b1;
        wb_ctrl_d   = ctrl_q;
        wb_result_d = load_d;
      end
      default: ;
    endcase
  end

  always_comb begin
    MemWE    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    case (state)
      STORE: begin
        MemWE    = 1'b1;
        MemAddr  = lane_addr(addr_q, lane);
        MemWData = wdata_q[lane];
      end
      LOAD: begin
        MemAddr = lane_addr(addr_q, lane);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      load_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_result_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      load_q      <= load_d;
      wb_valid_q  <= wb_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_result_q <= wb_result_d;
    end
  end

  assign WBValid     = wb_valid_q;
  assign RegWriteW   = wb_ctrl_q.regwrite;
  assign MemtoRegW   = wb_ctrl_q.memtoreg;
  assign FlagsWriteW = wb_ctrl_q.flagswrite;
  assign WA3W        = wb_ctrl_q.wa3;
  assign ALUFlagsW   = wb_ctrl_q.flags;
  assign ResultW     = wb_result_q;

endmodule

// File: tb/tb_vec_mem_stage.sv
// Directed bench for vec_mem_stage: pass-through, store, load, address wrap,
// reset mid-load and back-to-back acceptance against a byte memory model.
module tb_vec_mem_stage;
  import vec_pkg::*;

  logic         clk;
  logic         reset;
  logic         InValid;
  logic         RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE;
  logic [3:0]   WA3E;
  lanes_t       ALUOutputE, WriteDataE;
  flags_t       ALUFlagsE;
  logic [I-1:0] A;
  logic         Stall;
  logic [I-1:0] MemAddr;
  lane_t        MemWData;
  logic         MemWE;
  lane_t        MemRData;
  logic         WBValid, RegWriteW, MemtoRegW, FlagsWriteW;
  logic [3:0]   WA3W;
  flags_t       ALUFlagsW;
  lanes_t       ResultW;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  mem [logic [31:0]];

  vec_mem_stage dut (
    .clk         (clk),
    .reset       (reset),
    .InValid     (InValid),
    .RegWriteE   (RegWriteE),
    .MemtoRegE   (MemtoRegE),
    .MemWriteE   (MemWriteE),
    .FlagsWriteE (FlagsWriteE),
    .WA3E        (WA3E),
    .ALUOutputE  (ALUOutputE),
    .WriteDataE  (WriteDataE),
    .ALUFlagsE   (ALUFlagsE),
    .A           (A),
    .Stall       (Stall),
    .MemAddr     (MemAddr),
    .MemWData    (MemWData),
    .MemWE       (MemWE),
    .MemRData    (MemRData),
    .WBValid     (WBValid),
    .RegWriteW   (RegWriteW),
    .MemtoRegW   (MemtoRegW),
    .FlagsWriteW (FlagsWriteW),
    .WA3W        (WA3W),
    .ALUFlagsW   (ALUFlagsW),
    .ResultW     (ResultW)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port byte memory with synchronous read
  always @(posedge clk) begin
    MemRData <= mem.exists(MemAddr) ? mem[MemAddr] : 8'h00;
    if (MemWE === 1'b1) mem[MemAddr] = MemWData;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard for memory writes
  always @(negedge clk) begin
    logic [39:0] e;
    if (MemWE === 1'b1) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      chk("store_write", 64'({MemAddr, MemWData}), 64'(e));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    InValid = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; FlagsWriteE = 0;
    WA3E = '0; ALUOutputE = '0; WriteDataE = '0; ALUFlagsE = '0; A = '0;
  endtask

  task automatic push_store(input logic [31:0] base, input logic [7:0] first);
    for (int i = 0; i < R; i++) exp_q.push_back({base + 32'(i), first + 8'(i)});
  endtask

  initial begin
    for (int i = 0; i < R; i++) mem[32'h200 + 32'(i)] = 8'h10 + 8'(i);
    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;

    // Reset state
    chk("rst_stall", 64'(Stall), 0);
    chk("rst_wbvalid", 64'(WBValid), 0);
    chk("rst_memwe", 64'(MemWE), 0);
    chk("rst_memaddr", 64'(MemAddr), 0);
    chk("rst_result", 64'(ResultW), 0);
    chk("rst_flags", 64'(ALUFlagsW), 0);

    // Pass-through
    InValid = 1; RegWriteE = 1; WA3E = 4'd5;
    ALUOutputE = 48'h060504030201; ALUFlagsE = 12'hA5C;
    chk("pt_stall_c0", 64'(Stall), 0);
    tick(); clear_inputs();
    chk("pt_wbvalid", 64'(WBValid), 1);
    chk("pt_wa3", 64'(WA3W), 5);
    chk("pt_result", 64'(ResultW), 64'h060504030201);
    chk("pt_regwrite", 64'(RegWriteW), 1);
    chk("pt_memtoreg", 64'(MemtoRegW), 0);
    chk("pt_flags", 64'(ALUFlagsW), 64'hA5C);
    chk("pt_stall_c1", 64'(Stall), 0);
    tick();
    chk("pt_wbvalid_c2", 64'(WBValid), 0);
    chk("pt_hold", 64'(ResultW), 64'h060504030201);

    // Store
    InValid = 1; MemWriteE = 1; FlagsWriteE = 1; WA3E = 4'd3; A = 32'h100;
    WriteDataE = 48'hA5A4A3A2A1A0; ALUOutputE = 48'h161514131211;
    push_store(32'h100, 8'hA0);
    tick(); clear_inputs();
    for (int c = 1; c <= R; c++) begin
      chk("st_stall", 64'(Stall), 1);
      chk("st_memwe", 64'(MemWE), 1);
      chk("st_addr", 64'(MemAddr), 64'(32'h100 + 32'(c - 1)));
      chk("st_wdata", 64'(MemWData), 64'(8'hA0 + 8'(c - 1)));
      chk("st_wbvalid_busy", 64'(WBValid), 0);
      tick();
    end
    chk("st_wbvalid", 64'(WBValid), 1);
    chk("st_stall_done", 64'(Stall), 0);
    chk("st_memwe_off", 64'(MemWE), 0);
    chk("st_result", 64'(ResultW), 64'h161514131211);
    chk("st_flagswrite", 64'(FlagsWriteW), 1);
    chk("st_wa3", 64'(WA3W), 3);
    tick();

    // Load
    InValid = 1; MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd7; A = 32'h200;
    ALUOutputE = 48'hDEADBEEFCAFE;
    tick(); clear_inputs();
    for (int c = 1; c <= R; c++) begin
      chk("ld_stall", 64'(Stall), 1);
      chk("ld_memwe", 64'(MemWE), 0);
      chk("ld_addr", 64'(MemAddr), 64'(32'h200 + 32'(c - 1)));
      tick();
    end
    chk("ld_drain_stall", 64'(Stall), 1);
    chk("ld_drain_addr", 64'(MemAddr), 0);
    chk("ld_drain_wbvalid", 64'(WBValid), 0);
    tick();
    chk("ld_wbvalid", 64'(WBValid), 1);
    chk("ld_result", 64'(ResultW), 64'h151413121110);
    chk("ld_memtoreg", 64'(MemtoRegW), 1);
    chk("ld_wa3", 64'(WA3W), 7);
    chk("ld_stall_done", 64'(Stall), 0);
    tick();

    // Address wrap
    InValid = 1; MemWriteE = 1; A = 32'hFFFFFFFE; WriteDataE = 48'hB5B4B3B2B1B0;
    push_store(32'hFFFFFFFE, 8'hB0);
    tick(); clear_inputs();
    chk("wr_addr0", 64'(MemAddr), 64'hFFFFFFFE); tick();
    chk("wr_addr1", 64'(MemAddr), 64'hFFFFFFFF); tick();
    chk("wr_addr2", 64'(MemAddr), 64'h0);        tick();
    chk("wr_addr3", 64'(MemAddr), 64'h1);        tick();
    chk("wr_addr4", 64'(MemAddr), 64'h2);        tick();
    chk("wr_addr5", 64'(MemAddr), 64'h3);        tick();
    chk("wr_wbvalid", 64'(WBValid), 1);
    tick();

    // Reset mid-load
    InValid = 1; MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd6; A = 32'h200;
    tick(); clear_inputs();
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rml_stall", 64'(Stall), 0);
    chk("rml_memwe", 64'(MemWE), 0);
    chk("rml_wbvalid", 64'(WBValid), 0);
    chk("rml_result", 64'(ResultW), 0);
    chk("rml_wa3", 64'(WA3W), 0);
    InValid = 1; RegWriteE = 1; WA3E = 4'd9; ALUOutputE = 48'h0A0B0C0D0E0F;
    tick(); clear_inputs();
    chk("rml_pt_wbvalid", 64'(WBValid), 1);
    chk("rml_pt_result", 64'(ResultW), 64'h0A0B0C0D0E0F);
    chk("rml_pt_wa3", 64'(WA3W), 9);
    for (int c = 0; c < R + 2; c++) begin
      tick();
      chk("rml_no_late_wb", 64'(WBValid), 0);
    end

    // Back-to-back: store flagged as load too, then a held pass-through
    InValid = 1; MemWriteE = 1; MemtoRegE = 1; WA3E = 4'd4; A = 32'h300;
    WriteDataE = 48'hC5C4C3C2C1C0; ALUOutputE = 48'h313233343536;
    push_store(32'h300, 8'hC0);
    tick();
    clear_inputs();
    InValid = 1; RegWriteE = 1; WA3E = 4'd2; ALUOutputE = 48'h777777777777;
    for (int c = 1; c <= R; c++) begin
      chk("b2b_stall", 64'(Stall), 1);
      chk("b2b_memwe", 64'(MemWE), 1);
      tick();
    end
    chk("b2b_st_wbvalid", 64'(WBValid), 1);
    chk("b2b_st_result", 64'(ResultW), 64'h313233343536);
    chk("b2b_st_memtoreg", 64'(MemtoRegW), 1);
    chk("b2b_st_wa3", 64'(WA3W), 4);
    chk("b2b_stall_low", 64'(Stall), 0);
    tick(); clear_inputs();
    chk("b2b_pt_wbvalid", 64'(WBValid), 1);
    chk("b2b_pt_wa3", 64'(WA3W), 2);
    chk("b2b_pt_result", 64'(ResultW), 64'h777777777777);
    chk("b2b_pt_memtoreg", 64'(MemtoRegW), 0);
    tick();
    chk("b2b_wbvalid_off", 64'(WBValid), 0);

    chk("store_queue_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_mem_stage.md
# vec_mem_stage

Vector memory stage of the RSA pipeline CPU: sits directly downstream of the vector execute stage and upstream of writeback. It accepts one vector instruction per handshake: ALU lane results, store data lanes, the computed byte address and the control flags. Loads and stores move R lanes sequentially, one byte per cycle, over a single-port byte memory. The stage then presents one registered writeback bundle and holds the upstream stage via `Stall` while busy.

## Interface
- `I`, 32, address width (bits)
- `N`, 8, lane width (bits) = memory data width
- `R`, 6, lane count
- `clk` in 1, single clock, all state on rising edge
- `reset` in 1, synchronous, active-high
- `InValid` in 1, execute stage presents an instruction
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `FlagsWriteE` in 1 each, control flags
- `WA3E` in 4, destination vector register
- `ALUOutputE` in [R-1:0][N-1:0], ALU lane results
- `WriteDataE` in [R-1:0][N-1:0], store data lanes
- `ALUFlagsE` in [R-1:0][1:0], per-lane flags
- `A` in I, base byte address
- `Stall` out 1, upstream must hold its outputs
- `MemAddr` out I, memory byte address
- `MemWData` out N, store byte
- `MemWE` out 1, memory write strobe
- `MemRData` in N, read byte, valid one cycle after `MemAddr` (synchronous read)
- `WBValid` out 1, writeback bundle valid (one-cycle pulse)
- `RegWriteW`, `MemtoRegW`, `FlagsWriteW` out 1 each
- `WA3W` out 4
- `ALUFlagsW` out [R-1:0][1:0]
- `ResultW` out [R-1:0][N-1:0], ALU result or loaded lanes

## Operation
- Accept = `InValid && !Stall`. On accept, all inputs are captured into internal registers; inputs are ignored afterwards.
- `Stall` = state != IDLE (registered state, combinational decode).
- States: IDLE, STORE, LOAD, LOAD_DRAIN.
- Classification at accept:
  - MemWriteE=1 → store; MemWriteE has priority over MemtoRegE.
  - Else MemtoRegE=1 → load.
  - Else pass-through.
- Pass-through: stays IDLE. WB registers load captured values, `ResultW`=ALUOutputE.
- STORE: lane counter k=0..R-1, one lane per cycle, lane 0 first.
  - `MemWE`=1, `MemAddr`=A+k, `MemWData`=WriteDataE[k].
  - After k=R-1 → IDLE and WB registers load. `ResultW` = captured ALUOutputE; the remaining flags pass through as captured.
- LOAD: for k=0..R-1, `MemAddr`=A+k, `MemWE`=0.
  - `MemRData` arriving the following cycle is written to lane k-1's slot, i.e. the lane addressed one cycle earlier.
  - After k=R-1 → LOAD_DRAIN, which captures lane R-1 → IDLE. WB registers then load with `ResultW` = loaded lanes.
- Address arithmetic: A+k modulo 2^I; wraps from all-ones to zero.
- Idle/STORE-off outputs: `MemAddr`=0, `MemWData`=0, `MemWE`=0 whenever not in STORE/LOAD.
- Reset (any state, including mid-transfer):
  - Next state is IDLE; lane counter = 0.
  - All outputs = 0, including `Stall`, `WBValid`, `ResultW`, `ALUFlagsW`.
  - Partial load data is discarded. Bytes already written to memory remain.
  - A `WBValid` pending for the reset cycle is suppressed.

## Timing
- Accept at the end of cycle 0.
- Pass-through: `WBValid` in cycle 1; `Stall` never asserted.
- Store:
  - `MemWE` and `Stall` high in cycles 1..R.
  - `WBValid` in cycle R+1; `Stall` low in R+1.
- Load:
  - Addresses issued in cycles 1..R; data captured at the ends of cycles 2..R+1.
  - `Stall` high in cycles 1..R+1; `WBValid` in cycle R+2.
- Next instruction is accepted at the end of the first cycle with `Stall`=0, so back-to-back pass-throughs sustain one per cycle.
- WB outputs hold their last value between `WBValid` pulses; only `WBValid` pulses.

## Structure
- Shared package `vec_pkg`:
  - Parameters I, N, R.
  - `lane_t` = logic [N-1:0] and `lanes_t` = lane_t [R-1:0].
  - `flags_t` = logic [R-1:0][1:0].
  - State enum `mem_state_t` {IDLE, STORE, LOAD, LOAD_DRAIN}.
- One sub-module `vec_lane_seq`: lane counter plus FSM. It outputs the current lane index, `last`, and state; the datapath muxing stays in the top module.

## Test plan
- Pass-through: RegWriteE=1, WA3E=5, ALUOutputE lanes 0x01..0x06 → cycle 1: WBValid=1, WA3W=5, ResultW lanes 0x01..0x06, Stall=0 throughout.
- Store: A=0x100, WriteDataE lanes 0xA0..0xA5 → cycles 1..6: MemWE=1, MemAddr 0x100..0x105, MemWData 0xA0..0xA5. WBValid in cycle 7.
- Load: memory 0x200..0x205 = 0x10..0x15, MemtoRegE=1 → ResultW lanes 0x10..0x15 with MemtoRegW=1 and WBValid in cycle 8. Stall high cycles 1..7.
- Wrap: store with A=0xFFFFFFFE → MemAddr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, 0x2, 0x3.
- Reset mid-load: reset asserted in cycle 3 → cycle 4: Stall=0, MemWE=0, WBValid=0, ResultW=0. No WBValid follows. A pass-through presented in cycle 4 yields WBValid in cycle 5.
- Back-to-back: store (MemWriteE=1 and MemtoRegE=1) immediately followed by pass-through held under Stall → store writes, not loads. Pass-through is accepted end of cycle 7; its WBValid is in cycle 8.
